array_match_sched: RTL
======================

# array_match_sched

Round-robin scheduler that shares one `array_match` comparator between `NREQ` requesters. Each requester submits a search key; the block grants one request at a time, snapshots the table, drives the comparator, and registers the result. It returns the match mask, the hit flag, and the lowest matching index over a valid/ready response channel tagged with the requester ID. It sits between the lookup clients and the single `array_match` instance.

## Interface
- `WIDTH`, 4, bits per table entry and per key
- `SIZE`, 8, table entries
- `NREQ`, 4, requesters (≥2)
- `IMPL`, 1, passed unchanged to `array_match`
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `table_i`  in  [SIZE-1:0][WIDTH-1:0]  table contents, sampled at grant
- `req_valid`  in  [NREQ-1:0]  per-requester request
- `req_key`  in  [NREQ-1:0][WIDTH-1:0]  per-requester key
- `req_ready`  out  [NREQ-1:0]  one-hot grant (acceptance)
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  IDW  granted requester index
- `rsp_mask`  out  SIZE  bit i set iff entry i == key
- `rsp_hit`  out  1  |rsp_mask
- `rsp_first`  out  IXW  lowest set index of rsp_mask; 0 when no hit
- `rsp_count`  out  CNTW  popcount of rsp_mask (only with macro, see Configuration)

## Operation
- FSM states: IDLE, CMP, RSP.
- IDLE: if any `req_valid`, choose winner g by round-robin starting at (rr_q+1) mod NREQ; assert `req_ready[g]` combinationally in this cycle; on the clock edge capture key_q, id_q=g, table_q=`table_i`, rr_q=g; go to CMP. Otherwise stay in IDLE with `req_ready`=0.
- CMP: `array_match` sees `in`=table_q, `match_value`=key_q. Register mask, hit, first, and count; go to RSP.
- RSP: `rsp_valid`=1. All `rsp_*` outputs are held stable until `rsp_ready`. On the handshake, go to IDLE.
- `req_ready` is 0 in CMP and RSP. Requesters hold `req_valid`/`req_key` until accepted. A requester that drops `req_valid` before grant simply loses its turn.
- Round-robin: a requester that is granted drops to lowest priority. With all requesters always requesting, grants cycle 0,1,…,NREQ-1,0.
- Widths: IDW=$clog2(NREQ), IXW=$clog2(SIZE), CNTW=$clog2(SIZE+1).
- `table_i` changes after the grant do not affect the in-flight search.

## Timing
- Reset values: state=IDLE, rr_q=NREQ-1 (requester 0 wins first), `req_ready`=0, `rsp_valid`=0, `rsp_id`/`rsp_mask`/`rsp_hit`/`rsp_first`/`rsp_count`=0.
- Grant in cycle T. `rsp_valid` rises at edge T+2.
- With `rsp_ready`=1 the handshake completes in cycle T+2. The next grant is possible in cycle T+3, so throughput is one search per 3 cycles.
- Backpressure: RSP persists indefinitely. No new grant is issued while a response is pending.
- Reset mid-operation (CMP or RSP): all state clears immediately. The in-flight search is dropped with no response, and rr_q returns to NREQ-1.
- Simultaneous `req_valid` and `rst_n` deassertion edge: no grant occurs until the first edge after reset release.

## Configuration
- `ARRAY_MATCH_SCHED_COUNT_EN` defined: the `rsp_count` port and its popcount register exist; the count is registered in CMP alongside the mask.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `array_match_sched_pkg` holds:
  - the state enum (IDLE, CMP, RSP);
  - width helper functions for IDW, IXW, and CNTW;
  - a pure function `first_set(mask)` that returns the lowest set index;
  - a pure function `popcount(mask)`.
- Sub-module: exactly one, the existing `array_match`, instantiated with WIDTH, SIZE, and IMPL. The round-robin picker stays inline.

## Test plan
Table for all cases: entries 0..7 = {1,2,3,2,1,2,3,1}.
- Single requester 0, key 2 → `rsp_mask`=8'b00101010, hit=1, first=1, count=3, `rsp_id`=0, `rsp_valid` two cycles after `req_ready[0]`.
- Key 0 → mask=0, hit=0, first=0, count=0.
- All four requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0; one grant every 3 cycles; `req_ready` always one-hot or 0.
- `rsp_ready` held 0 for 5 cycles during RSP → outputs stable, `req_ready`=0 throughout; handshake on cycle 6, then next grant.
- `table_i` entry 1 changed to 0 one cycle after grant, key 2 → mask still 8'b00101010.
- `rst_n` pulsed low during CMP → `rsp_valid` stays 0, no response; the next request from requesters 2 and 0 together grants 0 first.

Source files
------------

// File: rtl/array_match_sched_pkg.sv
// array_match_sched_pkg: shared types and helpers for the array_match_sched
// scheduler.
//   state_t      - scheduler FSM states (IDLE, CMP, RSP)
//   idw/ixw/cntw - widths of the requester ID, the entry index and the popcount
//   first_set    - lowest set bit index of a mask (0 when the mask is empty)
//   popcount     - number of set bits in a mask
// Both mask helpers take a MASK_MAX-bit argument. Callers zero-extend their
// SIZE-bit mask to that width.
package array_match_sched_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RSP = 2'd2} state_t;

  localparam int MASK_MAX = 64;

  function automatic int idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int ixw(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int cntw(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int first_set(input logic [MASK_MAX-1:0] mask);
    int r;
    r = 0;
    // Scanning downward leaves the lowest set index in r.
    for (int i = MASK_MAX - 1; i >= 0; i--)
      if (mask[i]) r = i;
    return r;
  endfunction

  function automatic int popcount(input logic [MASK_MAX-1:0] mask);
    int r;
    r = 0;
    for (int i = 0; i < MASK_MAX; i++)
      r += int'(mask[i]);
    return r;
  endfunction

endpackage

// File: rtl/array_match.sv
// array_match: combinational table search. Bit i of match is set when
// in[i] == match_value.
//   WIDTH - bits per entry and per key
//   SIZE  - number of table entries
//   IMPL  - 0 selects a direct equality compare; any other value selects an
//           XOR-and-NOR-reduce compare. Both give the same result.
// Ports: in (table contents), match_value (key), match (one bit per entry).
module array_match #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 8,
  parameter int IMPL  = 1
) (
  input  logic [SIZE-1:0][WIDTH-1:0] in,
  input  logic [WIDTH-1:0]           match_value,
  output logic [SIZE-1:0]            match
);

  for (genvar i = 0; i < SIZE; i++) begin : g_ent
    if (IMPL == 0) begin : g_eq
      assign match[i] = (in[i] == match_value);
    end else begin : g_xor
      assign match[i] = ~|(in[i] ^ match_value);
    end
  end

endmodule

// File: rtl/array_match_sched.sv
// array_match_sched: round-robin scheduler that lets NREQ requesters share
// one array_match comparator.
// Each search takes 3 cycles:
//   grant (IDLE) -> compare (CMP) -> respond (RSP)
// A response is held in RSP until the consumer accepts it.
// Ports:
//   clk, rst_n           - clock; asynchronous active-low reset
//   table_i              - table contents, snapshotted at grant
//   req_valid/req_key    - per-requester request and search key
//   req_ready            - one-hot grant, asserted combinationally in IDLE
//   rsp_valid/rsp_ready  - response handshake
//   rsp_id               - ID of the requester that was granted
//   rsp_mask             - per-entry match bits
//   rsp_hit              - set when any entry matched
//   rsp_first            - lowest matching index (0 when there is no hit)
//   rsp_count            - number of matching entries
// Build option: when ARRAY_MATCH_SCHED_COUNT_EN is defined, the rsp_count port
// and its popcount register are built. Otherwise they are absent.
module array_match_sched
  import array_match_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SIZE  = 8,
  parameter int NREQ  = 4,
  parameter int IMPL  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SIZE-1:0][WIDTH-1:0] table_i,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0] req_key,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [idw(NREQ)-1:0]       rsp_id,
  output logic [SIZE-1:0]            rsp_mask,
  output logic                       rsp_hit,
  output logic [ixw(SIZE)-1:0]       rsp_first
`ifdef ARRAY_MATCH_SCHED_COUNT_EN
  ,
  output logic [cntw(SIZE)-1:0]      rsp_count
`endif
);

  localparam int IDW  = idw(NREQ);
  localparam int IXW  = ixw(SIZE);
  localparam int CNTW = cntw(SIZE);

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [SIZE-1:0] mask;
    logic            hit;
    logic [IXW-1:0]  first;
`ifdef ARRAY_MATCH_SCHED_COUNT_EN
    logic [CNTW-1:0] count;
`endif
  } rsp_t;

  state_t                     state_q, state_d;
  logic [IDW-1:0]             rr_q, id_q, gnt_idx;
  logic [WIDTH-1:0]           key_q;
  logic [SIZE-1:0][WIDTH-1:0] table_q;
  logic [SIZE-1:0]            match_w;
  logic                       gnt_found, grant;
  rsp_t                       rsp_q, rsp_d;

  // Round-robin pick: search upward from the requester after the last winner.
  always_comb begin
    logic [IDW-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_q) + k) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // Gating with rst_n keeps req_ready low while reset is held. A request that
  // is already valid at reset release is granted only after the first edge.
  assign grant = (state_q == IDLE) && gnt_found && rst_n;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: if (grant) begin
        req_ready[gnt_idx] = 1'b1;
        state_d            = CMP;
      end
      CMP:  state_d = RSP;
      RSP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  array_match #(.WIDTH(WIDTH), .SIZE(SIZE), .IMPL(IMPL)) u_match (
    .in          (table_q),
    .match_value (key_q),
    .match       (match_w)
  );

  always_comb begin
    rsp_d       = '0;
    rsp_d.id    = id_q;
    rsp_d.mask  = match_w;
    rsp_d.hit   = |match_w;
    rsp_d.first = IXW'(first_set(MASK_MAX'(match_w)));
`ifdef ARRAY_MATCH_SCHED_COUNT_EN
    rsp_d.count = CNTW'(popcount(MASK_MAX'(match_w)));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= IDW'(NREQ - 1);
      id_q    <= '0;
      key_q   <= '0;
      table_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        key_q   <= req_key[gnt_idx];
        id_q    <= gnt_idx;
        table_q <= table_i;
        rr_q    <= gnt_idx;
      end
      if (state_q == CMP) rsp_q <= rsp_d;
    end
  end

  assign rsp_valid = (state_q == RSP);
  assign rsp_id    = rsp_q.id;
  assign rsp_mask  = rsp_q.mask;
  assign rsp_hit   = rsp_q.hit;
  assign rsp_first = rsp_q.first;
`ifdef ARRAY_MATCH_SCHED_COUNT_EN
  assign rsp_count = rsp_q.count;
`endif

endmodule
